mod_exp_ctrl: RTL and testbench

Sequencer for modular exponentiation on the Montgomery multiplier datapath. It computes result = base^exp mod modulus using left-to-right square-and-multiply, issuing one Montgomery product at a time to the multiplier and holding the accumulator between operations. A final multiply by 1 converts the result out of the Montgomery domain. It sits between the RSA top-level command interface and the single multiplier instance.

---
 rtl/mod_exp_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Purpose : left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
// Latency : start -> first mul_start 2 cycles; last mul_end fall -> done 2 cycles.
// Backpr. : one product in flight; waits for mul_end high then low; start ignored while busy.
//
// Ports
//   clk, rstn           : clock (rising edge), asynchronous active-low reset
//   start               : one-cycle request, only sampled while idle
//   len, ebits, exp     : Montgomery length, exponent bit count (clamped to WIDTH), exponent
//   base_m, one_m       : base and 1 in Montgomery form
//   modulus             : odd modulus n
//   mul_start/a/b/mod/len, mul_end, mm_out : multiplier launch / operands / completion
//   busy, done, err     : status; done and err are one-cycle pulses
//   result              : final value in the normal domain, valid from done
module mod_exp_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic [5:0]       ebits,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] base_m,
    input  logic [WIDTH-1:0] one_m,
    input  logic [WIDTH-1:0] modulus,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_mod,
    output logic [7:0]       mul_len,
    input  logic             mul_end,
    input  logic [WIDTH-1:0] mm_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_MUL,
        S_CONV,
        S_WAIT_END,
        S_WAIT_LOW,
        S_FIN
    } state_t;

    // Which operation is in flight, so WAIT_LOW knows where to go next.
    typedef enum logic [1:0] {
        T_SQ,
        T_MUL,
        T_CONV
    } tag_t;

    state_t           state_q, state_d;
    tag_t             tag_q, tag_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic             mul_start_q, mul_start_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] mul_mod_q, mul_mod_d;
    logic [7:0]       mul_len_q, mul_len_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Exponent bit count clamped to the operand width.
    logic [6:0] eff_bits;
    always_comb begin
        eff_bits = {1'b0, ebits};
        if ({1'b0, ebits} > 7'(WIDTH)) begin
            eff_bits = 7'(WIDTH);
        end
    end

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        exp_d       = exp_q;
        base_d      = base_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_mod_d   = mul_mod_q;
        mul_len_d   = mul_len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        result_d    = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    acc_d     = one_m;
                    exp_d     = exp;
                    base_d    = base_m;
                    mul_mod_d = modulus;
                    mul_len_d = len;
                    // With zero exponent bits the index is never used.
                    idx_d     = IW'(eff_bits - 7'd1);
                    state_d   = (eff_bits == 7'd0) ? S_CONV : S_SQ;
                end
            end
            S_SQ: begin
                mul_a_d     = acc_q;
                mul_b_d     = acc_q;
                mul_start_d = 1'b1;
                cnt_d       = '0;
                tag_d       = T_SQ;
                state_d     = S_WAIT_END;
            end
            S_MUL: begin
                mul_a_d     = acc_q;
                mul_b_d     = base_q;
                mul_start_d = 1'b1;
                cnt_d       = '0;
                tag_d       = T_MUL;
                state_d     = S_WAIT_END;
            end
            S_CONV: begin
                // Product with plain 1 strips the R factor.
                mul_a_d     = acc_q;
                mul_b_d     = WIDTH'(1);
                mul_start_d = 1'b1;
                cnt_d       = '0;
                tag_d       = T_CONV;
                state_d     = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (mul_end) begin
                    acc_d   = mm_out;
                    state_d = S_WAIT_LOW;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_LOW: begin
                // Holding off until mul_end drops keeps the next launch
                // clear of the previous completion.
                if (!mul_end) begin
                    unique case (tag_q)
                        T_SQ: begin
                            if (exp_q[idx_q]) begin
                                state_d = S_MUL;
                            end else if (idx_q == '0) begin
                                state_d = S_CONV;
                            end else begin
                                idx_d   = idx_q - IW'(1);
                                state_d = S_SQ;
                            end
                        end
                        T_MUL: begin
                            if (idx_q == '0) begin
                                state_d = S_CONV;
                            end else begin
                                idx_d   = idx_q - IW'(1);
                                state_d = S_SQ;
                            end
                        end
                        default: begin
                            result_d = acc_q;
                            state_d  = S_FIN;
                        end
                    endcase
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            tag_q       <= T_SQ;
            idx_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            exp_q       <= '0;
            base_q      <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_mod_q   <= '0;
            mul_len_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            exp_q       <= exp_d;
            base_q      <= base_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_mod_q   <= mul_mod_d;
            mul_len_q   <= mul_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
        end
    end

    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_mod   = mul_mod_q;
    assign mul_len   = mul_len_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
module tb_mod_exp_ctrl;

    localparam int W  = 32;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   len = '0;
    logic [5:0]   ebits = '0;
    logic [W-1:0] exp_i = '0;
    logic [W-1:0] base_m = '0;
    logic [W-1:0] one_m = '0;
    logic [W-1:0] modulus = '0;
    logic         mul_start;
    logic [W-1:0] mul_a, mul_b, mul_mod;
    logic [7:0]   mul_len;
    logic         mul_end = 1'b0;
    logic [W-1:0] mm_out = '0;
    logic         busy, done, err;
    logic [W-1:0] result;

    mod_exp_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .ebits(ebits),
        .exp(exp_i), .base_m(base_m), .one_m(one_m), .modulus(modulus),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_mod(mul_mod),
        .mul_len(mul_len), .mul_end(mul_end), .mm_out(mm_out),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        bit          is_err;
        logic [31:0] res;
        int          ops;
    } exp_t;
    exp_t sb_q[$];

    int          start_cyc = 0;
    int          ops_cnt = 0;
    int          fall_cyc = 0;
    int          mstart_cyc = 0;
    bit          hang = 1'b0;
    logic [31:0] last_result = '0;
    logic [31:0] cur_mod = '0;
    logic [7:0]  cur_len = '0;
    logic [31:0] last_a = '0, last_b = '0;
    string       op_log = "";

    // Montgomery product a*b*2^-l mod n, bit-serial.
    function automatic longint mont(input longint a, input longint b, input longint n, input int l);
        longint t = 0;
        for (int k = 0; k < l; k++) begin
            if (a[k]) t += b;
            if (t[0]) t += n;
            t = t >> 1;
        end
        if (t >= n) t -= n;
        return t;
    endfunction

    // Right-to-left binary exponentiation in the normal domain.
    function automatic longint modpow(input longint b, input longint e, input int eb, input longint n);
        longint r = 1 % n;
        longint p = b % n;
        for (int k = 0; k < eb; k++) begin
            if (e[k]) r = (r * p) % n;
            p = (p * p) % n;
        end
        return r;
    endfunction

    task automatic issue(input longint n, input int l, input longint base, input longint e,
                         input int eb_raw, input bit expect_err);
        exp_t   x;
        int     eb;
        longint em;
        eb = (eb_raw > 32) ? 32 : eb_raw;
        em = e & ((longint'(1) << eb) - 1);
        x.is_err = expect_err;
        x.res    = 32'(modpow(base, em, eb, n));
        x.ops    = eb + $countones(em) + 1;
        @(negedge clk);
        modulus   = 32'(n);
        len       = 8'(l);
        base_m    = 32'((base << l) % n);
        one_m     = 32'((longint'(1) << l) % n);
        exp_i     = 32'(e);
        ebits     = 6'(eb_raw);
        start     = 1'b1;
        cur_mod   = 32'(n);
        cur_len   = 8'(l);
        start_cyc = cyc;
        ops_cnt   = 0;
        op_log    = "";
        sb_q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            #1;
            if (!busy && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_wait busy=%0d pending=%0d required idle", tag, busy, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Behavioural multiplier plus launch-side protocol checks.
    initial begin
        int     ph = 0;
        int     cnt = 0;
        bit     prev_start = 1'b0;
        longint res = 0;
        logic [31:0] la = '0, lb = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mul_end    = 1'b0;
                ph         = 0;
                prev_start = 1'b0;
                continue;
            end
            if (mul_start) begin
                chk("start_back_to_back", 64'(prev_start), 64'd0);
                chk("start_while_end", 64'(mul_end), 64'd0);
                ops_cnt++;
                mstart_cyc = cyc;
                if (ops_cnt == 1) chk("first_start_latency", 64'(cyc - start_cyc), 64'd2);
                chk("mul_mod", 64'(mul_mod), 64'(cur_mod));
                chk("mul_len", 64'(mul_len), 64'(cur_len));
                if (mul_b == 32'd1) op_log = {op_log, "C"};
                else if (mul_a == mul_b) op_log = {op_log, "S"};
                else op_log = {op_log, "M"};
                last_a = mul_a;
                last_b = mul_b;
                la = mul_a;
                lb = mul_b;
                if (!hang) begin
                    res = mont(longint'(la), longint'(lb), longint'(cur_mod), int'(cur_len));
                    cnt = $urandom_range(1, 6);
                    ph  = 1;
                end
            end else if (ph == 1) begin
                chk("operand_hold", 64'(mul_a == la && mul_b == lb), 64'd1);
                cnt--;
                if (cnt == 0) begin
                    mul_end = 1'b1;
                    mm_out  = 32'(res);
                    cnt     = $urandom_range(1, 3);
                    ph      = 2;
                end
            end else if (ph == 2) begin
                cnt--;
                if (cnt == 0) begin
                    mul_end  = 1'b0;
                    fall_cyc = cyc;
                    ph       = 0;
                end
            end
            prev_start = mul_start;
        end
    end

    // Completion monitor: pops the scoreboard on done / err.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rstn && (done || err)) begin
                chk("done_err_exclusive", 64'(done && err), 64'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_end done=%0d err=%0d required none", done, err);
                end else begin
                    x = sb_q.pop_front();
                    chk("end_kind_err", 64'(err), 64'(x.is_err));
                    chk("busy_at_end", 64'(busy), 64'd0);
                    if (!x.is_err) begin
                        chk("result", 64'(result), 64'(x.res));
                        chk("op_count", 64'(ops_cnt), 64'(x.ops));
                        chk("done_latency", 64'(cyc - fall_cyc), 64'd2);
                        last_result = x.res;
                    end else begin
                        chk("err_latency", 64'(cyc - mstart_cyc), 64'(TO + 1));
                        chk("err_result_kept", 64'(result), 64'(last_result));
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
        chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
        chk({tag, "_mul_mod"}, 64'(mul_mod), 64'd0);
        chk({tag, "_mul_len"}, 64'(mul_len), 64'd0);
    endtask

    initial begin
        bit     seen;
        longint n, b;
        #3 rstn = 1'b0;
        #1 check_reset_vals("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Worked example: 2^5 mod 13.
        issue(13, 4, 2, 5, 3, 1'b0);
        wait_idle("example");
        chk("example_seq_is_SMSSMC", 64'(op_log == "SMSSMC"), 64'd1);

        // Zero exponent bits: conversion only.
        issue(13, 4, 2, 0, 0, 1'b0);
        wait_idle("ebits0");
        chk("ebits0_ops", 64'(ops_cnt), 64'd1);
        chk("ebits0_mul_a", 64'(last_a), 64'd3);
        chk("ebits0_mul_b", 64'(last_b), 64'd1);

        // ebits above 32 clamps to 32.
        n = longint'($urandom_range(3, 65535) | 1);
        issue(n, 16, longint'($urandom) % n, 64'hFFFF_FFFF, 40, 1'b0);
        wait_idle("clamp");
        chk("clamp_ops", 64'(ops_cnt), 64'd65);

        // Randomized operands.
        for (int t = 0; t < 20; t++) begin
            n = longint'($urandom_range(3, 65535) | 1);
            b = longint'($urandom) % n;
            issue(n, 16, b, longint'($urandom), $urandom_range(0, 40), 1'b0);
            wait_idle("random");
        end

        // Start while busy with different operands is ignored.
        issue(13, 4, 2, 5, 3, 1'b0);
        repeat (5) @(negedge clk);
        modulus = 32'd101; len = 8'd7; base_m = 32'd55; one_m = 32'd27;
        exp_i = 32'hFF; ebits = 6'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("start_busy");

        // Reset in the middle of the MUL wait, then a fresh run.
        issue(13, 4, 2, 5, 3, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            #1;
            if (ops_cnt == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reached_mul_wait", 64'(seen), 64'd1);
        chk("mul_wait_busy", 64'(busy), 64'd1);
        #1 rstn = 1'b0;
        #1 check_reset_vals("midreset");
        sb_q.delete();
        last_result = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        issue(13, 4, 2, 5, 3, 1'b0);
        wait_idle("after_reset");

        // Multiplier that never completes: timeout.
        hang = 1'b1;
        n = longint'($urandom_range(3, 65535) | 1);
        issue(n, 16, 5 % n, 7, 3, 1'b1);
        wait_idle("timeout");
        hang = 1'b0;

        // Recovery after the timeout.
        n = longint'($urandom_range(3, 65535) | 1);
        issue(n, 16, longint'($urandom) % n, longint'($urandom), 32, 1'b0);
        wait_idle("recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
